// File: rtl/cbfp_denorm_module.sv
// cbfp_denorm_module: undoes CBFP block normalisation at the FFT output.
// Exponent sets from the CBFP stage are queued in a FIFO. Each later normalised
// 16-lane complex vector pops the oldest set, and each lane is rescaled by
// 2^(TRUNC_VALUE-idx) with saturation to OUT_W. Latency is 2 clk.
`timescale 1ns/1ps
module cbfp_denorm_module #(
  parameter int IN_W        = 12,
  parameter int OUT_W       = 16,
  parameter int NCHAN       = 16,
  parameter int BLOCK_SIZE  = 8,
  parameter int NBLOCKS     = 2,
  parameter int EXP_W       = 5,
  parameter int TRUNC_VALUE = 13,
  parameter int FIFO_DEPTH  = 32
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               exp_valid,
  input  logic [NBLOCKS-1:0][EXP_W-1:0]      exp_in,
  output logic                               exp_ready,
  input  logic                               data_valid,
  input  logic [NCHAN-1:0][IN_W-1:0]         data_re_in,
  input  logic [NCHAN-1:0][IN_W-1:0]         data_im_in,
  output logic [NCHAN-1:0][OUT_W-1:0]        data_re_out,
  output logic [NCHAN-1:0][OUT_W-1:0]        data_im_out,
  output logic                               valid_out,
  output logic                               sat_flag,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
  output logic                               err_overflow,
  output logic                               err_underflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SET_W  = NBLOCKS * EXP_W;
  localparam int SH_W   = EXP_W + 2;
  localparam int WIDE_W = IN_W + TRUNC_VALUE;

  localparam logic signed [WIDE_W-1:0] MAX_W = WIDE_W'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [WIDE_W-1:0] MIN_W = WIDE_W'(-(1 <<< (OUT_W - 1)));

  // Arithmetic scale by 2^s: left shift for s>=0, floor right shift otherwise.
  function automatic logic signed [WIDE_W-1:0] scale(input logic signed [IN_W-1:0] x,
                                                     input logic signed [SH_W-1:0] s);
    logic signed [WIDE_W-1:0] w;
    logic        [SH_W-1:0]   amt;
    w = WIDE_W'(x);
    if (s[SH_W-1]) begin
      amt   = SH_W'(-s);
      scale = w >>> amt;
    end else begin
      amt   = SH_W'(s);
      scale = w <<< amt;
    end
  endfunction

  // Clamp the wide value into the OUT_W signed range.
  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [WIDE_W-1:0] w);
    if (w > MAX_W)      saturate = OUT_W'(MAX_W);
    else if (w < MIN_W) saturate = OUT_W'(MIN_W);
    else                saturate = w[OUT_W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [WIDE_W-1:0] w);
    clipped = (w > MAX_W) || (w < MIN_W);
  endfunction

  logic [SET_W-1:0]               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]               wr_ptr;
  logic [PTR_W-1:0]               rd_ptr;
  logic [CNT_W-1:0]               count;
  logic                           full;
  logic                           empty;
  logic                           push;
  logic                           pop;
  logic [NBLOCKS-1:0][EXP_W-1:0]  exp_rd;

  logic                           vld_p1;
  logic signed [IN_W-1:0]         re_p1 [NCHAN];
  logic signed [IN_W-1:0]         im_p1 [NCHAN];
  logic signed [SH_W-1:0]         sh_p1 [NBLOCKS];

  logic signed [WIDE_W-1:0]       wide_re [NCHAN];
  logic signed [WIDE_W-1:0]       wide_im [NCHAN];
  logic                           any_sat;

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign push       = exp_valid && !full;
  assign pop        = data_valid && !empty;
  assign exp_ready  = !full;
  assign fifo_count = count;
  assign exp_rd     = mem[rd_ptr];

  // Exponent FIFO storage; write only on an accepted push.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= exp_in;
  end

  // FIFO pointers, occupancy, sticky error flags and the valid pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      vld_p1        <= 1'b0;
      valid_out     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (exp_valid && full)   err_overflow  <= 1'b1;
      if (data_valid && empty) err_underflow <= 1'b1;
      vld_p1    <= pop;
      valid_out <= vld_p1;
    end
  end

  // ---- stage 1: capture lanes and per-block shift from the popped exponent set
  always_ff @(posedge clk) begin
    if (pop) begin
      for (int i = 0; i < NCHAN; i++) begin
        re_p1[i] <= $signed(data_re_in[i]);
        im_p1[i] <= $signed(data_im_in[i]);
      end
      for (int b = 0; b < NBLOCKS; b++) begin
        sh_p1[b] <= $signed(SH_W'(TRUNC_VALUE)) - $signed({2'b00, exp_rd[b]});
      end
    end
  end

  // Per-lane rescale using the shift of the block the lane belongs to.
  always_comb begin
    any_sat = 1'b0;
    for (int b = 0; b < NBLOCKS; b++) begin
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        wide_re[b*BLOCK_SIZE+k] = scale(re_p1[b*BLOCK_SIZE+k], sh_p1[b]);
        wide_im[b*BLOCK_SIZE+k] = scale(im_p1[b*BLOCK_SIZE+k], sh_p1[b]);
      end
    end
    for (int i = 0; i < NCHAN; i++) begin
      any_sat = any_sat | clipped(wide_re[i]) | clipped(wide_im[i]);
    end
  end

  // ---- stage 2: saturated outputs, held while no new vector arrives
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_re_out <= '0;
      data_im_out <= '0;
      sat_flag    <= 1'b0;
    end else if (vld_p1) begin
      for (int i = 0; i < NCHAN; i++) begin
        data_re_out[i] <= saturate(wide_re[i]);
        data_im_out[i] <= saturate(wide_im[i]);
      end
      sat_flag <= any_sat;
    end
  end

endmodule

// File: tb/tb_cbfp_denorm_module.sv
// Directed bench for cbfp_denorm_module with a scoreboard queue and an
// independent monitor comparing every valid_out vector in order.
`timescale 1ns/1ps
module tb_cbfp_denorm_module;

  localparam int IN_W = 12, OUT_W = 16, NCHAN = 16, BLOCK_SIZE = 8, NBLOCKS = 2;
  localparam int EXP_W = 5, TRUNC_VALUE = 13, FIFO_DEPTH = 32;

  typedef struct packed {
    logic [NCHAN-1:0][OUT_W-1:0] re;
    logic [NCHAN-1:0][OUT_W-1:0] im;
    logic                        sat;
  } exp_t;

  logic                          clk = 1'b0;
  logic                          rstn;
  logic                          exp_valid;
  logic [NBLOCKS-1:0][EXP_W-1:0] exp_in;
  logic                          exp_ready;
  logic                          data_valid;
  logic [NCHAN-1:0][IN_W-1:0]    data_re_in;
  logic [NCHAN-1:0][IN_W-1:0]    data_im_in;
  logic [NCHAN-1:0][OUT_W-1:0]   data_re_out;
  logic [NCHAN-1:0][OUT_W-1:0]   data_im_out;
  logic                          valid_out;
  logic                          sat_flag;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          err_overflow;
  logic                          err_underflow;

  int   total = 0;
  int   bad   = 0;
  exp_t sb [$];
  exp_t mon_e;
  exp_t e;
  logic [NCHAN-1:0][IN_W-1:0] r;
  logic [NCHAN-1:0][IN_W-1:0] m;

  cbfp_denorm_module #(
    .IN_W(IN_W), .OUT_W(OUT_W), .NCHAN(NCHAN), .BLOCK_SIZE(BLOCK_SIZE),
    .NBLOCKS(NBLOCKS), .EXP_W(EXP_W), .TRUNC_VALUE(TRUNC_VALUE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .exp_valid(exp_valid), .exp_in(exp_in), .exp_ready(exp_ready),
    .data_valid(data_valid), .data_re_in(data_re_in), .data_im_in(data_im_in),
    .data_re_out(data_re_out), .data_im_out(data_im_out),
    .valid_out(valid_out), .sat_flag(sat_flag), .fifo_count(fifo_count),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Monitor: every valid output vector must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rstn === 1'b1 && valid_out === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid re=%h im=%h", data_re_out, data_im_out);
      end else begin
        mon_e = sb.pop_front();
        if (data_re_out !== mon_e.re || data_im_out !== mon_e.im || sat_flag !== mon_e.sat) begin
          bad++;
          $display("FAIL vector got re=%h im=%h sat=%b want re=%h im=%h sat=%b",
                   data_re_out, data_im_out, sat_flag, mon_e.re, mon_e.im, mon_e.sat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    exp_valid  = 1'b0;
    data_valid = 1'b0;
    exp_in     = '0;
    data_re_in = '0;
    data_im_in = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic push_exp(input int e0, input int e1);
    exp_valid = 1'b1;
    exp_in[0] = EXP_W'(e0);
    exp_in[1] = EXP_W'(e1);
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic drive_vec(input logic [NCHAN-1:0][IN_W-1:0] re,
                           input logic [NCHAN-1:0][IN_W-1:0] im, input exp_t want);
    data_valid = 1'b1;
    data_re_in = re;
    data_im_in = im;
    sb.push_back(want);
    tick();
  endtask

  initial begin
    do_reset();
    check("rst_valid_out", valid_out, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_exp_ready", exp_ready, 1);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_err_underflow", err_underflow, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_re_out", data_re_out[0], 0);

    // Push and data on an empty FIFO in the same cycle: data dropped, set stored.
    exp_valid = 1'b1; exp_in[0] = 5'd13; exp_in[1] = 5'd13;
    data_valid = 1'b1; data_re_in = '0; data_re_in[0] = 12'(77);
    tick();
    exp_valid = 1'b0; data_valid = 1'b0;
    check("nobypass_count", fifo_count, 1);
    check("underflow_set", err_underflow, 1);

    push_exp(10, 16);
    push_exp(0, 0);
    push_exp(0, 0);
    push_exp(13, 13);
    check("count_after_push", fifo_count, 5);

    // v1: identity scaling, 2-cycle latency.
    r = '0; m = '0; e = '0;
    r[0] = 12'(100); m[0] = 12'(-100);
    e.re[0] = 16'(100); e.im[0] = 16'(-100); e.sat = 1'b0;
    drive_vec(r, m, e);
    data_valid = 1'b0;
    check("latency_cycle1", valid_out, 0);
    tick();
    check("latency_cycle2", valid_out, 1);

    // v2: block0 shift +3, block1 shift -3 (floor).
    r = '0; m = '0; e = '0;
    r[0] = 12'(100); r[7] = 12'(1); r[8] = 12'(-9); r[15] = 12'(-2048); m[8] = 12'(9);
    e.re[0] = 16'(800); e.re[7] = 16'(8); e.re[8] = 16'(-2); e.re[15] = 16'(-256);
    e.im[8] = 16'(1); e.sat = 1'b0;
    drive_vec(r, m, e);
    // v3: shift 13, positive clip.
    r = '0; m = '0; e = '0;
    r[3] = 12'(5); m[12] = 12'(-1);
    e.re[3] = 16'(32767); e.im[12] = 16'(-8192); e.sat = 1'b1;
    drive_vec(r, m, e);
    // v4: shift 13, negative clip.
    r = '0; m = '0; e = '0;
    r[3] = 12'(-5); m[0] = 12'(3);
    e.re[3] = 16'(-32768); e.im[0] = 16'(24576); e.sat = 1'b1;
    drive_vec(r, m, e);
    // v5: identity again, sat_flag must drop.
    r = '0; m = '0; e = '0;
    r[5] = 12'(-1); m[10] = 12'(2047);
    e.re[5] = 16'(-1); e.im[10] = 16'(2047); e.sat = 1'b0;
    drive_vec(r, m, e);
    data_valid = 1'b0;
    repeat (4) tick();
    check("count_drained", fifo_count, 0);
    check("underflow_sticky", err_underflow, 1);
    check("no_overflow", err_overflow, 0);
    check("sb_empty_1", sb.size(), 0);

    // Overflow: fill, then one extra push.
    do_reset();
    check("underflow_cleared", err_underflow, 0);
    exp_valid = 1'b1; exp_in[0] = 5'd13; exp_in[1] = 5'd13;
    repeat (31) tick();
    check("count_31", fifo_count, 31);
    check("ready_at_31", exp_ready, 1);
    tick();
    check("count_32", fifo_count, 32);
    check("ready_at_32", exp_ready, 0);
    check("ovf_not_yet", err_overflow, 0);
    tick();
    exp_valid = 1'b0;
    check("ovf_set", err_overflow, 1);
    check("count_held_32", fifo_count, 32);

    // Full-rate push+pop burst, then reset mid-burst.
    do_reset();
    push_exp(13, 13);
    for (int i = 0; i < 10; i++) begin
      exp_valid = 1'b1; exp_in[0] = 5'd13; exp_in[1] = 5'd13;
      r = '0; m = '0; e = '0;
      r[0] = 12'(i + 1); m[0] = 12'(-(i + 1)); r[15] = 12'(2047); m[15] = 12'(-2048);
      e.re[0] = 16'(i + 1); e.im[0] = 16'(-(i + 1));
      e.re[15] = 16'(2047); e.im[15] = 16'(-2048); e.sat = 1'b0;
      drive_vec(r, m, e);
    end
    check("burst_count", fifo_count, 1);
    check("burst_no_underflow", err_underflow, 0);
    check("burst_valid_active", valid_out, 1);
    rstn = 1'b0;
    sb.delete();
    #1;
    check("midrst_valid_out", valid_out, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_exp_ready", exp_ready, 1);
    check("midrst_re_out", data_re_out[0], 0);
    check("midrst_sat_flag", sat_flag, 0);
    exp_valid = 1'b0; data_valid = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (4) tick();
    check("post_rst_count", fifo_count, 0);
    check("post_rst_errors", {err_overflow, err_underflow}, 0);

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
